jk_bank_arbiter: RTL and testbench

- Shares one bank of WIDTH JK flip-flops between two requesters.
- Each requester issues a masked JK operation (hold/reset/set/toggle) through a req/grant handshake.
- Round-robin arbitration; one operation at a time, sequenced by a 4-state FSM.
- Sits between control logic and the JK storage bank; the bank's Q is exported for readback.

---
 rtl/jk_bank_arbiter_pkg.sv | 21 ++
 rtl/jk_bank_arbiter_bank.sv | 27 ++
 rtl/jk_bank_arbiter.sv | 99 +++++++++
 tb/tb_jk_bank_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_arbiter_pkg.sv
// Shared encodings for the JK bank arbiter: FSM states and JK operation codes.
package jk_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        APPLY = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    // Expand one {J,K} op across a bit mask; unselected bits get J=K=0.
    function automatic logic [31:0] op_mask(input logic op_bit, input logic [31:0] sel);
        return op_bit ? sel : 32'd0;
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_bank.sv
// Bank of WIDTH independent JK flip-flops with asynchronous active-low clear.
module jk_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ff
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q[i] <= 1'b0;
            end else begin
                case ({j[i], k[i]})
                    2'b01:   q[i] <= 1'b0;
                    2'b10:   q[i] <= 1'b1;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin arbiter sequencing masked JK operations onto a shared bank.
module jk_bank_arbiter
    import jk_bank_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_b,
    input  logic             Req0,
    input  logic [1:0]       Op0,
    input  logic [WIDTH-1:0] Sel0,
    input  logic             Req1,
    input  logic [1:0]       Op1,
    input  logic [WIDTH-1:0] Sel1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Q
);

    state_e           state, state_nxt;
    logic             win_q, win_nxt, take;
    logic             last_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] sel_q;
    logic [WIDTH-1:0] bank_j, bank_k;

    always_ff @(posedge Clk or negedge Rst_b) begin
        if (!Rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        win_nxt   = win_q;
        Gnt0      = 1'b0;
        Gnt1      = 1'b0;
        Busy      = 1'b1;
        Done      = 1'b0;
        bank_j    = '0;
        bank_k    = '0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                // last_q==1 means requester 1 was served last, so 0 wins a tie.
                if (Req0 && (!Req1 || last_q)) begin
                    take    = 1'b1;
                    win_nxt = 1'b0;
                end else if (Req1) begin
                    take    = 1'b1;
                    win_nxt = 1'b1;
                end
                if (take) state_nxt = GRANT;
            end
            GRANT: begin
                Gnt0      = ~win_q;
                Gnt1      = win_q;
                state_nxt = APPLY;
            end
            APPLY: begin
                bank_j    = WIDTH'(op_mask(op_q[1], 32'(sel_q)));
                bank_k    = WIDTH'(op_mask(op_q[0], 32'(sel_q)));
                state_nxt = DONE;
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_b) begin
        if (!Rst_b) begin
            win_q  <= 1'b0;
            last_q <= 1'b1;
            op_q   <= OP_HOLD;
            sel_q  <= '0;
        end else begin
            if (take) begin
                win_q <= win_nxt;
                op_q  <= win_nxt ? Op1 : Op0;
                sel_q <= win_nxt ? Sel1 : Sel0;
            end
            if (state == APPLY) last_q <= win_q;
        end
    end

    jk_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (Clk),
        .rst_n (Rst_b),
        .j     (bank_j),
        .k     (bank_k),
        .q     (Q)
    );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: vector table of single operations plus hand-written corner sequences.
module tb_jk_bank_arbiter;

    localparam int WIDTH = 4;

    logic             Clk = 1'b0;
    logic             Rst_b;
    logic             Req0, Req1;
    logic [1:0]       Op0, Op1;
    logic [WIDTH-1:0] Sel0, Sel1;
    logic             Gnt0, Gnt1, Busy, Done;
    logic [WIDTH-1:0] Q;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    jk_bank_arbiter #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Rst_b(Rst_b),
        .Req0(Req0), .Op0(Op0), .Sel0(Sel0),
        .Req1(Req1), .Op1(Op1), .Sel1(Sel1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Busy(Busy), .Done(Done), .Q(Q)
    );

    typedef struct {
        logic             side;
        logic [1:0]       op;
        logic [WIDTH-1:0] sel;
        logic [WIDTH-1:0] exp_q;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Req0 = 0; Req1 = 0; Op0 = 0; Op1 = 0; Sel0 = 0; Sel1 = 0;
    endtask

    // Waits (bounded) at negedges for either grant; returns {Gnt1,Gnt0}.
    task automatic wait_gnt(input string name, output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (Gnt0 || Gnt1) begin
                g = {Gnt1, Gnt0};
                break;
            end
        end
        if (g == 2'b00) check({name, "_gnt_timeout"}, 1, 0);
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({name, "_done_timeout"}, 1, 0);
    endtask

    task automatic do_reset();
        Rst_b = 0;
        @(negedge Clk);
        Rst_b = 1;
        @(negedge Clk);
    endtask

    initial begin
        logic [1:0] g;
        idle_inputs();
        Rst_b = 0;

        // Reset with random requests: outputs forced to zero.
        for (int i = 0; i < 4; i++) begin
            Req0 = 1'($urandom); Req1 = 1'($urandom);
            Op0 = 2'($urandom); Op1 = 2'($urandom);
            Sel0 = 4'($urandom); Sel1 = 4'($urandom);
            @(negedge Clk);
            check("rst_outs", {Gnt0, Gnt1, Busy, Done, Q}, 0);
        end
        idle_inputs();
        Rst_b = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("post_rst_idle", {Gnt0, Gnt1, Busy, Done, Q}, 0);
        end

        // Single set, cycle by cycle.
        Req0 = 1; Op0 = 2'b10; Sel0 = 4'b0101;
        @(negedge Clk);
        check("set_c1", {Gnt0, Gnt1, Busy, Done, Q}, {4'b1010, 4'b0000});
        Req0 = 0;
        @(negedge Clk);
        check("set_c2", {Gnt0, Gnt1, Busy, Done, Q}, {4'b0010, 4'b0000});
        @(negedge Clk);
        check("set_c3", {Gnt0, Gnt1, Busy, Done, Q}, {4'b0011, 4'b0101});
        @(negedge Clk);
        check("set_c4", {Gnt0, Gnt1, Busy, Done, Q}, {4'b0000, 4'b0101});

        // Vector table of single-requester operations, chained from Q=0101.
        vecs[0] = '{1'b1, 2'b11, 4'b1111, 4'b1010};
        vecs[1] = '{1'b1, 2'b01, 4'b1000, 4'b0010};
        vecs[2] = '{1'b0, 2'b00, 4'b1111, 4'b0010};
        vecs[3] = '{1'b0, 2'b11, 4'b0000, 4'b0010};
        vecs[4] = '{1'b1, 2'b10, 4'b0011, 4'b0011};
        vecs[5] = '{1'b0, 2'b11, 4'b0110, 4'b0101};
        foreach (vecs[i]) begin
            if (vecs[i].side) begin Req1 = 1; Op1 = vecs[i].op; Sel1 = vecs[i].sel; end
            else              begin Req0 = 1; Op0 = vecs[i].op; Sel0 = vecs[i].sel; end
            wait_gnt("vec", g);
            check($sformatf("vec%0d_gnt", i), g, vecs[i].side ? 2'b10 : 2'b01);
            idle_inputs();
            wait_done("vec");
            check($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
            @(negedge Clk);
        end

        // Contention from reset: 0 first, then 1, then 0 again on the next tie.
        do_reset();
        Req0 = 1; Op0 = 2'b10; Sel0 = 4'b0001;
        Req1 = 1; Op1 = 2'b10; Sel1 = 4'b0100;
        wait_gnt("cont_a", g);
        check("cont_a_gnt", g, 2'b01);
        Req0 = 0;
        wait_done("cont_a");
        check("cont_a_q", Q, 4'b0001);
        wait_gnt("cont_b", g);
        check("cont_b_gnt", g, 2'b10);
        Req1 = 0;
        wait_done("cont_b");
        check("cont_b_q", Q, 4'b0101);
        @(negedge Clk);
        Req0 = 1; Op0 = 2'b11; Sel0 = 4'b1111;
        Req1 = 1; Op1 = 2'b01; Sel1 = 4'b1111;
        wait_gnt("cont_c", g);
        check("cont_c_gnt", g, 2'b01);
        Req0 = 0;
        wait_done("cont_c");
        check("cont_c_q", Q, 4'b1010);
        wait_gnt("cont_d", g);
        check("cont_d_gnt", g, 2'b10);
        Req1 = 0;
        wait_done("cont_d");
        check("cont_d_q", Q, 4'b0000);
        @(negedge Clk);

        // Request pulsed between edges is never sampled.
        Req0 = 1; Op0 = 2'b10; Sel0 = 4'b1111;
        #2 Req0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("lost_req", {Gnt0, Gnt1, Busy, Done, Q}, 0);
        end

        // Reset during APPLY discards the in-flight set.
        Req0 = 1; Op0 = 2'b10; Sel0 = 4'b1111;
        wait_gnt("mid", g);
        check("mid_gnt", g, 2'b01);
        idle_inputs();
        @(posedge Clk);
        #2;
        check("mid_busy_apply", Busy, 1);
        Rst_b = 0;
        #1;
        check("mid_rst_outs", {Gnt0, Gnt1, Busy, Done, Q}, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_b = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("mid_after", {Gnt0, Gnt1, Busy, Done, Q}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
